// File: rtl/cpu_player_ctrl.sv
// CPU opponent driver: turns ball/player positions into the same keycode and
// keycode2 streams a keyboard would produce, with rate-limited moves and time-boxed jumps.
module cpu_player_ctrl #(
  parameter int REACT_FRAMES  = 4,
  parameter int DEADBAND      = 8,
  parameter int KICK_OFFSET   = 16,
  parameter int X_TARGET_MAX  = 615,
  parameter int GROUND_Y      = 428,
  parameter int JUMP_XWIN     = 40,
  parameter int JUMP_YWIN     = 64,
  parameter int JUMP_HOLD     = 3,
  parameter int JUMP_COOLDOWN = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  output logic [7:0] keycode,
  output logic [7:0] keycode2,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRACK    = 2'd1,
    ST_JUMP     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  localparam int RW   = (REACT_FRAMES > 1) ? $clog2(REACT_FRAMES) : 1;
  localparam int JMAX = (JUMP_HOLD > JUMP_COOLDOWN) ? JUMP_HOLD : JUMP_COOLDOWN;
  localparam int JW   = (JMAX > 1) ? $clog2(JMAX) : 1;

  localparam logic [RW-1:0] RCT_LAST  = RW'(REACT_FRAMES - 1);
  localparam logic [JW-1:0] HOLD_LAST = JW'(JUMP_HOLD - 1);
  localparam logic [JW-1:0] COOL_LAST = JW'(JUMP_COOLDOWN - 1);

  localparam logic [10:0] KICK_OFF11 = 11'(KICK_OFFSET);
  localparam logic [10:0] XMAX11     = 11'(X_TARGET_MAX);
  localparam logic [10:0] DEAD11     = 11'(DEADBAND);
  localparam logic [10:0] GROUND11   = 11'(GROUND_Y);
  localparam logic [10:0] XWIN11     = 11'(JUMP_XWIN);
  localparam logic [10:0] YWIN11     = 11'(JUMP_YWIN);

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_JUMP  = 8'h1A;

  state_t        state_reg, state_next;
  logic [RW-1:0] rct_reg, rct_next;
  logic [JW-1:0] jcnt_reg, jcnt_next;
  logic [7:0]    keycode_reg, keycode_next;
  logic [7:0]    keycode2_reg, keycode2_next;

  // Widened to 11 bits so offsets and differences never wrap.
  logic [10:0] ball_x, ball_y, player_x, player_y;
  logic [10:0] tgt_raw, tgt, dx, dy;
  logic        move_right, move_left, jump_cond;
  logic [7:0]  decision;

  assign ball_x   = {1'b0, BallX};
  assign ball_y   = {1'b0, BallY};
  assign player_x = {1'b0, PlayerX};
  assign player_y = {1'b0, PlayerY};

  assign tgt_raw    = ball_x + KICK_OFF11;
  assign tgt        = (tgt_raw > XMAX11) ? XMAX11 : tgt_raw;
  assign move_right = (player_x + DEAD11) < tgt;
  assign move_left  = player_x > (tgt + DEAD11);
  assign decision   = move_right ? KEY_RIGHT : (move_left ? KEY_LEFT : KEY_NONE);

  assign dx = (ball_x >= player_x) ? (ball_x - player_x) : (player_x - ball_x);
  assign dy = player_y - ball_y;
  assign jump_cond = (player_y >= GROUND11) && (ball_y < player_y) &&
                     (dy <= YWIN11) && (dx <= XWIN11);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      rct_reg      <= '0;
      jcnt_reg     <= '0;
      keycode_reg  <= KEY_NONE;
      keycode2_reg <= KEY_NONE;
    end else begin
      state_reg    <= state_next;
      rct_reg      <= rct_next;
      jcnt_reg     <= jcnt_next;
      keycode_reg  <= keycode_next;
      keycode2_reg <= keycode2_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rct_next      = rct_reg;
    jcnt_next     = jcnt_reg;
    keycode_next  = keycode_reg;
    keycode2_next = keycode2_reg;
    if (!Enable) begin
      state_next    = ST_IDLE;
      rct_next      = '0;
      jcnt_next     = '0;
      keycode_next  = KEY_NONE;
      keycode2_next = KEY_NONE;
    end else if (state_reg == ST_IDLE) begin
      state_next    = ST_TRACK;
      rct_next      = '0;
      jcnt_next     = '0;
      keycode2_next = KEY_NONE;
    end else begin
      // Horizontal decisions run in every active state, once per react period.
      if (rct_reg == RCT_LAST) begin
        rct_next     = '0;
        keycode_next = decision;
      end else begin
        rct_next = rct_reg + 1'b1;
      end
      case (state_reg)
        ST_TRACK: begin
          keycode2_next = KEY_NONE;
          if (jump_cond) begin
            state_next    = ST_JUMP;
            keycode2_next = KEY_JUMP;
            jcnt_next     = '0;
          end
        end
        ST_JUMP: begin
          if (jcnt_reg == HOLD_LAST) begin
            state_next    = ST_COOLDOWN;
            keycode2_next = KEY_NONE;
            jcnt_next     = '0;
          end else begin
            keycode2_next = KEY_JUMP;
            jcnt_next     = jcnt_reg + 1'b1;
          end
        end
        ST_COOLDOWN: begin
          keycode2_next = KEY_NONE;
          if (jcnt_reg == COOL_LAST) begin
            state_next = ST_TRACK;
            jcnt_next  = '0;
          end else begin
            jcnt_next = jcnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign keycode  = keycode_reg;
  assign keycode2 = keycode2_reg;
  assign State    = state_reg;

endmodule

// File: tb/tb_cpu_player_ctrl.sv
// Scoreboard bench for cpu_player_ctrl: stimulus queues the expected frame
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_cpu_player_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       Enable;
  logic [9:0] BallX, BallY, PlayerX, PlayerY;
  logic [7:0] keycode, keycode2;
  logic [1:0] State;

  always #5 frame_clk = ~frame_clk;

  cpu_player_ctrl dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .Enable(Enable),
    .BallX(BallX),
    .BallY(BallY),
    .PlayerX(PlayerX),
    .PlayerY(PlayerY),
    .keycode(keycode),
    .keycode2(keycode2),
    .State(State)
  );

  typedef struct {
    logic [1:0] st;
    logic [7:0] kc;
    logic [7:0] kc2;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string tag, input logic [1:0] st, input logic [7:0] kc,
                     input logic [7:0] kc2);
    n_cmp++;
    if (State !== st || keycode !== kc || keycode2 !== kc2) begin
      n_bad++;
      $display("FAIL %s: got State=%0d keycode=%h keycode2=%h, want State=%0d keycode=%h keycode2=%h",
               tag, State, keycode, keycode2, st, kc, kc2);
    end else begin
      $display("ok   %s: State=%0d keycode=%h keycode2=%h", tag, State, keycode, keycode2);
    end
  endtask

  // One frame: expectation is the DUT state right after the next edge.
  task automatic tick(input logic [1:0] st, input logic [7:0] kc, input logic [7:0] kc2,
                      input string tag);
    exp_t e;
    @(posedge frame_clk);
    #1;
    e.st  = st;
    e.kc  = kc;
    e.kc2 = kc2;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic set_in(input int bx, input int by, input int px, input int py);
    BallX   = 10'(bx);
    BallY   = 10'(by);
    PlayerX = 10'(px);
    PlayerY = 10'(py);
  endtask

  // One react period starting from rct=0: three held frames, then the new decision.
  task automatic period(input logic [1:0] st, input logic [7:0] old_kc, input logic [7:0] new_kc,
                        input string tag);
    for (int i = 0; i < 3; i++) tick(st, old_kc, 8'h00, {tag, "_hold"});
    tick(st, new_kc, 8'h00, tag);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge frame_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.tag, e.st, e.kc, e.kc2);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [1:0] st;
    logic [7:0] kc, kc2;
    Reset  = 1'b1;
    Enable = 1'b0;
    set_in(0, 0, 0, 0);
    #12;
    cmp("reset", 2'd0, 8'h00, 8'h00);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) tick(2'd0, 8'h00, 8'h00, "idle_hold");

    // Enable: first decision lands exactly REACT_FRAMES edges later.
    Enable = 1'b1;
    set_in(400, 200, 100, 428);
    tick(2'd1, 8'h00, 8'h00, "enable_track");
    period(2'd1, 8'h00, 8'h07, "first_right");
    PlayerX = 10'd500;
    period(2'd1, 8'h07, 8'h04, "move_left");
    PlayerX = 10'd420;
    period(2'd1, 8'h04, 8'h00, "deadband");

    // Jump held true: 3 jump frames, 30 cooldown, 1 track, then re-jump.
    set_in(320, 380, 300, 428);
    for (int i = 0; i < 35; i++) begin
      st  = (i < 3) ? 2'd2 : (i < 33) ? 2'd3 : (i == 33) ? 2'd1 : 2'd2;
      kc  = (i >= 3) ? 8'h07 : 8'h00;
      kc2 = (st == 2'd2) ? 8'h1A : 8'h00;
      tick(st, kc, kc2, $sformatf("jump_f%0d", i));
    end
    tick(2'd2, 8'h07, 8'h1A, "rejump_f2");
    Enable = 1'b0;
    tick(2'd0, 8'h00, 8'h00, "disable_midjump");
    tick(2'd0, 8'h00, 8'h00, "disabled_idle");

    // Re-enable restarts the full react delay.
    Enable = 1'b1;
    set_in(400, 200, 100, 428);
    tick(2'd1, 8'h00, 8'h00, "reenable_track");
    period(2'd1, 8'h00, 8'h07, "reenable_right");

    // Target clamps at 615; neither wrap nor overshoot.
    set_in(1023, 200, 610, 428);
    period(2'd1, 8'h07, 8'h00, "clamp_still");
    PlayerX = 10'd700;
    period(2'd1, 8'h00, 8'h04, "clamp_left");
    PlayerX = 10'd600;
    period(2'd1, 8'h04, 8'h07, "clamp_right");

    // Enter cooldown, then reset asynchronously between edges.
    set_in(320, 380, 300, 428);
    for (int i = 0; i < 3; i++) tick(2'd2, 8'h07, 8'h1A, "jump_b");
    for (int i = 0; i < 5; i++) tick(2'd3, 8'h07, 8'h00, "cooldown_b");
    @(negedge frame_clk);
    #2;
    Reset = 1'b1;
    #1;
    cmp("async_reset", 2'd0, 8'h00, 8'h00);
    @(posedge frame_clk);
    #1;
    cmp("reset_held", 2'd0, 8'h00, 8'h00);
    Reset = 1'b0;
    tick(2'd1, 8'h00, 8'h00, "after_reset_track");
    tick(2'd2, 8'h00, 8'h1A, "after_reset_jump");

    @(negedge frame_clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
